// File: rtl/jtag_debug_ocimem_ctrl.sv
// Sysclk-side debug memory controller: turns decoded JTAG actions into single-word
// read/write transactions with address auto-increment and a bus timeout.
module jtag_debug_ocimem_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [DATA_W-1:0] mon_dreg, mon_nxt;
  logic [DATA_W-1:0] wdata, wdata_nxt;
  logic              err, err_nxt;
  logic              we, we_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              any_cmd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr     <= '0;
      mon_dreg <= '0;
      wdata    <= '0;
      err      <= 1'b0;
      we       <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      addr     <= addr_nxt;
      mon_dreg <= mon_nxt;
      wdata    <= wdata_nxt;
      err      <= err_nxt;
      we       <= we_nxt;
      cnt      <= cnt_nxt;
    end
  end

  // Command decode in IDLE (write > address load > read); ack/timeout/overrun in BUSY.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    mon_nxt   = mon_dreg;
    wdata_nxt = wdata;
    err_nxt   = err;
    we_nxt    = we;
    cnt_nxt   = cnt;
    any_cmd   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (take_action_ocimem_b) begin
          mon_nxt   = jdo[3 +: DATA_W];
          wdata_nxt = jdo[3 +: DATA_W];
          we_nxt    = 1'b1;
          state_nxt = BUSY;
        end else if (take_action_ocimem_a) begin
          addr_nxt = jdo[18 +: ADDR_W];
          if (jdo[34]) err_nxt = 1'b0;
          if (jdo[35]) begin
            we_nxt    = 1'b0;
            state_nxt = BUSY;
          end
        end else if (take_no_action_ocimem_a) begin
          we_nxt    = 1'b0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (any_cmd) err_nxt = 1'b1;
        // An ack coinciding with the last allowed cycle still completes normally.
        if (mem_ack) begin
          if (!we) mon_nxt = mem_rdata;
          addr_nxt  = addr + ADDR_W'(1);
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign MonDReg       = mon_dreg;
  assign monitor_ready = (state == IDLE);
  assign monitor_error = err;
  assign mem_req       = (state == BUSY);
  assign mem_we        = we;
  assign mem_addr      = addr;
  assign mem_wdata     = wdata;

endmodule

// File: tb/tb_jtag_debug_ocimem_ctrl.sv
// Testbench for jtag_debug_ocimem_ctrl: directed scenarios plus randomized transactions
// checked against a transaction-level model with a bench-side memory.
module tb_jtag_debug_ocimem_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_model [256];
  int          m_addr;
  logic [31:0] m_mon;
  bit          m_err;

  jtag_debug_ocimem_ctrl #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .reset(reset),
    .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .MonDReg(MonDReg),
    .monitor_ready(monitor_ready),
    .monitor_error(monitor_error),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives the pulses for one clock, starting and ending on a falling edge.
  task automatic applyStimulus(input bit a, input bit b, input bit n, input logic [37:0] j);
    take_action_ocimem_a    = a;
    take_action_ocimem_b    = b;
    take_no_action_ocimem_a = n;
    jdo                     = j;
    @(negedge clk);
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    jdo                     = {$urandom, $urandom};
  endtask

  function automatic logic [37:0] loadJdo(input bit rd, input bit clr, input logic [7:0] a);
    logic [37:0] j;
    j        = {$urandom, $urandom};
    j[35]    = rd;
    j[34]    = clr;
    j[25:18] = a;
    return j;
  endfunction

  function automatic logic [37:0] writeJdo(input logic [31:0] d);
    logic [37:0] j;
    j       = {$urandom, $urandom};
    j[34:3] = d;
    return j;
  endfunction

  // Plays the memory: acks in BUSY cycle d (never if d > TIMEOUT), optional overrun pulse in cycle ov.
  task automatic runBusy(input bit is_write, input logic [31:0] wd, input int d, input int ov);
    int limit;
    int kind;
    limit = (d <= TIMEOUT) ? d : TIMEOUT;
    for (int c = 1; c <= limit; c++) begin
      checkOutput("req_busy", mem_req, 1);
      checkOutput("ready_busy", monitor_ready, 0);
      if (c == 1) begin
        checkOutput("mem_addr", mem_addr, m_addr[7:0]);
        checkOutput("mem_we", mem_we, is_write);
        if (is_write) begin
          checkOutput("mem_wdata", mem_wdata, wd);
          checkOutput("mondreg_wr", MonDReg, wd);
        end
      end
      if (c == ov) begin
        kind = $urandom_range(0, 2);
        take_action_ocimem_a    = (kind == 0);
        take_action_ocimem_b    = (kind == 1);
        take_no_action_ocimem_a = (kind == 2);
      end
      if (c == d) begin
        mem_ack   = 1'b1;
        mem_rdata = is_write ? $urandom : mem_model[m_addr];
      end
      @(negedge clk);
      take_action_ocimem_a    = 1'b0;
      take_action_ocimem_b    = 1'b0;
      take_no_action_ocimem_a = 1'b0;
      mem_ack                 = 1'b0;
      mem_rdata               = $urandom;
    end
    if (ov > 0 && ov <= limit) m_err = 1'b1;
    if (d <= TIMEOUT) begin
      if (is_write) mem_model[m_addr] = wd;
      else          m_mon = mem_model[m_addr];
      m_addr = (m_addr + 1) % 256;
    end else begin
      m_err = 1'b1;
    end
    checkOutput("req_done", mem_req, 0);
    checkOutput("ready_done", monitor_ready, 1);
    checkOutput("mondreg", MonDReg, m_mon);
    checkOutput("error", monitor_error, m_err);
  endtask

  task automatic doWrite(input logic [31:0] d32, input int d, input int ov);
    applyStimulus(1'b0, 1'b1, 1'b0, writeJdo(d32));
    m_mon = d32;
    runBusy(1'b1, d32, d, ov);
  endtask

  task automatic doRead(input int d, input int ov);
    applyStimulus(1'b0, 1'b0, 1'b1, {$urandom, $urandom});
    runBusy(1'b0, '0, d, ov);
  endtask

  task automatic doLoad(input logic [7:0] a, input bit clr, input bit rd, input int d, input int ov);
    applyStimulus(1'b1, 1'b0, 1'b0, loadJdo(rd, clr, a));
    m_addr = a;
    if (clr) m_err = 1'b0;
    if (rd) begin
      runBusy(1'b0, '0, d, ov);
    end else begin
      checkOutput("load_req", mem_req, 0);
      checkOutput("load_ready", monitor_ready, 1);
      checkOutput("load_error", monitor_error, m_err);
    end
  endtask

  initial begin
    int kind, d, ov;
    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    mem_rdata = '0;
    mem_ack = 1'b0;
    for (int i = 0; i < 256; i++) mem_model[i] = $urandom;
    mem_model[8'hFF] = 32'hCAFEF00D;
    m_addr = 0;
    m_mon = '0;
    m_err = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_ready", monitor_ready, 1);
    checkOutput("rst_error", monitor_error, 0);
    checkOutput("rst_mondreg", MonDReg, 0);
    checkOutput("rst_req", mem_req, 0);
    checkOutput("rst_we", mem_we, 0);
    checkOutput("rst_wdata", mem_wdata, 0);
    @(negedge clk);

    // Write burst at 0x10, 0x11
    doLoad(8'h10, 1'b0, 1'b0, 0, 0);
    checkOutput("load_addr", mem_addr, 8'h10);
    doWrite(32'hDEADBEEF, 3, 0);
    doWrite(32'h12345678, 2, 0);
    checkOutput("burst_mon", MonDReg, 32'h12345678);

    // Read with address wrap
    doLoad(8'hFF, 1'b0, 1'b1, 2, 0);
    checkOutput("wrap_mon", MonDReg, 32'hCAFEF00D);
    doRead(1, 0);

    // Timeout, then error clear, then ack exactly in the last allowed cycle
    doRead(TIMEOUT + 5, 0);
    @(negedge clk);
    checkOutput("to_req_stays_low", mem_req, 0);
    doRead(1, 0);
    doLoad(8'h20, 1'b1, 1'b0, 0, 0);
    checkOutput("err_cleared", monitor_error, 0);
    doRead(TIMEOUT, 0);
    doWrite($urandom, TIMEOUT + 1, 0);

    // Overrun and priority
    doLoad(8'h30, 1'b1, 1'b0, 0, 0);
    doRead(3, 1);
    @(negedge clk);
    checkOutput("ovr_no_second_req", mem_req, 0);
    doLoad(8'h30, 1'b1, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, writeJdo(32'hA5A55A5A));
    m_mon = 32'hA5A55A5A;
    runBusy(1'b1, 32'hA5A55A5A, 2, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, loadJdo(1'b0, 1'b0, 8'h44));
    m_addr = 8'h44;
    checkOutput("prio_load_no_req", mem_req, 0);
    checkOutput("prio_load_addr", mem_addr, 8'h44);

    // Randomized transactions, with occasional stray ack in IDLE
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 3);
      d    = $urandom_range(1, TIMEOUT + 2);
      ov   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, (d > TIMEOUT) ? TIMEOUT : d) : 0;
      case (kind)
        0: doLoad(8'($urandom), 1'($urandom), 1'b0, 0, 0);
        1: doLoad(8'($urandom), 1'($urandom), 1'b1, d, ov);
        2: doWrite($urandom, d, ov);
        default: doRead(d, ov);
      endcase
      if ($urandom_range(0, 4) == 0) begin
        mem_ack = 1'b1;
        mem_rdata = $urandom;
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("idle_ack_mon", MonDReg, m_mon);
        checkOutput("idle_ack_req", mem_req, 0);
      end
    end

    // Reset in the 2nd BUSY cycle, followed by a late ack
    doWrite(32'h0BADF00D, 1, 0);
    doLoad(8'h40, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, {$urandom, $urandom});
    checkOutput("rmid_req1", mem_req, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_addr = 0;
    m_mon = '0;
    m_err = 1'b0;
    checkOutput("rmid_req", mem_req, 0);
    checkOutput("rmid_ready", monitor_ready, 1);
    checkOutput("rmid_mon", MonDReg, 0);
    checkOutput("rmid_err", monitor_error, 0);
    mem_ack = 1'b1;
    mem_rdata = $urandom;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("late_ack_mon", MonDReg, 0);
    checkOutput("late_ack_req", mem_req, 0);
    doRead(1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
